// File: rtl/debug_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus target between N_INIT initiators.
// Each grant issues a single read or write downstream, with write locks and an access timeout.
module debug_bus_arbiter #(
   parameter int N_INIT     = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [N_INIT-1:0]              req_i,
   input  logic [N_INIT*ADDR_WIDTH-1:0]   addr_i,
   input  logic [N_INIT-1:0]              write_i,
   input  logic [N_INIT*DATA_WIDTH-1:0]   wdata_i,
   input  logic [N_INIT*DATA_WIDTH/8-1:0] wstrb_i,
   input  logic [N_INIT-1:0]              lock_i,
   output logic [N_INIT-1:0]              gnt_o,
   output logic [N_INIT-1:0]              rsp_valid_o,
   output logic [DATA_WIDTH-1:0]          rdata_o,
   output logic                           error_o,
   output logic                           m_valid_o,
   output logic [ADDR_WIDTH-1:0]          m_addr_o,
   output logic                           m_write_o,
   output logic [DATA_WIDTH-1:0]          m_wdata_o,
   output logic [DATA_WIDTH/8-1:0]        m_wstrb_o,
   input  logic                           m_ready_i,
   input  logic [DATA_WIDTH-1:0]          m_rdata_i,
   input  logic                           m_error_i,
   output logic                           busy_o,
   output logic [$clog2(N_INIT)-1:0]      cur_id_o
);

   localparam int IW = $clog2(N_INIT);
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [IW:0]   NI        = (IW+1)'(N_INIT);
   localparam logic [IW-1:0] LAST_INIT = IW'(N_INIT - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic [IW-1:0]           r_last_id;
   logic [IW-1:0]           r_id;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_write;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [SW-1:0]           r_wstrb;
   logic                    r_locked;
   logic [CW-1:0]           r_cnt;
   logic                    r_gnt;
   logic                    r_hold;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_error;

   logic [ADDR_WIDTH-1:0]   w_addr  [N_INIT];
   logic [DATA_WIDTH-1:0]   w_wdata [N_INIT];
   logic [SW-1:0]           w_wstrb [N_INIT];

   logic                    w_sel_found;
   logic [IW-1:0]           w_sel_id;
   logic [IW:0]             w_sum;
   logic [IW:0]             w_idx;
   logic                    w_arb;
   logic                    w_timeout;
   logic [N_INIT-1:0]       w_id_onehot;

   generate
      for (genvar gi = 0; gi < N_INIT; gi++) begin : g_slice
         assign w_addr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_wdata[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
         assign w_wstrb[gi] = wstrb_i[gi*SW +: SW];
      end
   endgenerate

   // Search starts one past the last served initiator and wraps modulo N_INIT.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_id    = '0;
      w_sum       = '0;
      w_idx       = '0;
      for (int k = 1; k <= N_INIT; k++) begin
         w_sum = {1'b0, r_last_id} + k[IW:0];
         w_idx = (w_sum >= NI) ? (w_sum - NI) : w_sum;
         if (!w_sel_found && req_i[w_idx[IW-1:0]]) begin
            w_sel_found = 1'b1;
            w_sel_id    = w_idx[IW-1:0];
         end
      end
   end

   // r_hold gives one idle bubble after every response before re-arbitrating.
   assign w_arb       = (r_state == S_IDLE) && !r_hold && w_sel_found;
   assign w_timeout   = (r_cnt == TO_LAST);
   assign w_id_onehot = N_INIT'(1) << r_id;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_arb) begin
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_locked || m_ready_i || w_timeout) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last_id <= LAST_INIT;
         r_id      <= '0;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_locked  <= 1'b0;
         r_cnt     <= '0;
         r_gnt     <= 1'b0;
         r_hold    <= 1'b0;
         r_rdata   <= '0;
         r_error   <= 1'b0;
      end else begin
         r_gnt  <= 1'b0;
         r_hold <= (r_state == S_RESP);
         case (r_state)
            S_IDLE: begin
               if (w_arb) begin
                  r_id     <= w_sel_id;
                  r_addr   <= w_addr[w_sel_id];
                  r_write  <= write_i[w_sel_id];
                  r_wdata  <= w_wdata[w_sel_id];
                  r_wstrb  <= w_wstrb[w_sel_id];
                  // Lock only matters for writes; locked reads go through.
                  r_locked <= write_i[w_sel_id] & lock_i[w_sel_id];
                  r_cnt    <= '0;
                  r_gnt    <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (r_locked) begin
                  r_rdata <= '0;
                  r_error <= 1'b1;
               end else if (m_ready_i) begin
                  r_rdata <= m_rdata_i;
                  r_error <= m_error_i;
               end else if (w_timeout) begin
                  r_rdata <= '0;
                  r_error <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               r_last_id <= r_id;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign gnt_o       = r_gnt ? w_id_onehot : '0;
   assign rsp_valid_o = (r_state == S_RESP) ? w_id_onehot : '0;
   assign rdata_o     = (r_state == S_RESP) ? r_rdata : '0;
   assign error_o     = (r_state == S_RESP) ? r_error : 1'b0;
   assign m_valid_o   = (r_state == S_ISSUE) && !r_locked;
   assign m_addr_o    = r_addr;
   assign m_write_o   = r_write;
   assign m_wdata_o   = r_wdata;
   assign m_wstrb_o   = r_wstrb;
   assign busy_o      = (r_state != S_IDLE);
   assign cur_id_o    = r_id;

endmodule
